// File: rtl/param_pattern_pkg.sv
// Shared types and constants for the parametrised pattern sequencer.
// Holds the sequencer state encoding and the step-rule selectors for MODE.
package param_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MODE_ROTATE     = 0;
    localparam int MODE_COMPLEMENT = 1;
    localparam int MODE_HOLD       = 2;

endpackage

// File: rtl/param_pattern_step.sv
// Combinational next-pattern rule for the pattern sequencer.
// Ports: pat (current pattern) -> pat_next (pattern for the following step).
module param_pattern_step
    import param_pattern_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MODE  = MODE_ROTATE
) (
    input  logic [WIDTH-1:0] pat,
    output logic [WIDTH-1:0] pat_next
);

    always_comb begin
        pat_next = pat;
        if (MODE == MODE_ROTATE) begin
            // Rotate-left by one; degenerates to identity when WIDTH == 1.
            pat_next = (pat << 1) | (pat >> (WIDTH - 1));
        end else if (MODE == MODE_COMPLEMENT) begin
            pat_next = ~pat;
        end
    end

endmodule

// File: rtl/param_pattern_seq.sv
// Pattern source: idles at INIT_VAL^INV_MASK, plays STEPS steps of HOLD cycles on start.
// Ports: clk, rst (sync, active-high), start, stop -> o, busy, done. Option: PATTERN_SEQ_LOOP_EN.
module param_pattern_seq
    import param_pattern_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] INIT_VAL = 4'b0001,
    parameter logic [WIDTH-1:0] INV_MASK = 4'b0000,
    parameter int               STEPS    = 4,
    parameter int               HOLD     = 2,
    parameter int               MODE     = MODE_ROTATE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] o,
    output logic             busy,
    output logic             done
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);

    if (WIDTH < 1 || STEPS < 1 || HOLD < 1 || MODE < 0 || MODE > 2) begin : g_bad_param
        $error("param_pattern_seq: illegal parameter set");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d, pat_nx;
    logic [HW-1:0]    hold_q, hold_d;
    logic [SW-1:0]    step_q, step_d;
    logic             done_q, done_d;

    param_pattern_step #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_step (
        .pat      (pat_q),
        .pat_next (pat_nx)
    );

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        hold_d  = hold_q;
        step_d  = step_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // stop outranks both step advance and completion.
                if (stop) begin
                    state_d = IDLE;
                    pat_d   = INIT_VAL;
                    hold_d  = '0;
                    step_d  = '0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HW'(1);
                end else if (step_q != STEP_LAST) begin
                    pat_d  = pat_nx;
                    step_d = step_q + SW'(1);
                    hold_d = '0;
                end else begin
                    pat_d  = INIT_VAL;
                    step_d = '0;
                    hold_d = '0;
                    done_d = 1'b1;
`ifdef PATTERN_SEQ_LOOP_EN
                    state_d = RUN;
`else
                    state_d = DONE;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                pat_d   = INIT_VAL;
                hold_d  = '0;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= INIT_VAL;
            hold_q  <= '0;
            step_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hold_q  <= hold_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    // Outputs decode flops only, so no input-to-output combinational path.
    assign o    = pat_q ^ INV_MASK;
    assign busy = (state_q == RUN);
    assign done = done_q;

endmodule

// File: tb/tb_param_pattern_seq.sv
// Self-checking bench for param_pattern_seq across five parameter sets.
// Directed literal checks plus randomized start/stop/rst against a behavioural model.
module tb_param_pattern_seq;

`ifdef PATTERN_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    localparam int NI = 5;
    localparam int CW [NI] = '{4, 4, 4, 5, 1};
    localparam int CI [NI] = '{1, 1, 5, 18, 1};
    localparam int CM [NI] = '{0, 15, 0, 6, 0};
    localparam int CS [NI] = '{4, 4, 3, 2, 3};
    localparam int CH [NI] = '{2, 2, 1, 3, 1};
    localparam int CMD[NI] = '{0, 0, 1, 2, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic stop = 1'b0;
    logic [3:0] o0, o1, o2;
    logic [4:0] o3;
    logic [0:0] o4;
    logic [NI-1:0] busy_v, done_v;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    param_pattern_seq u0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .o(o0), .busy(busy_v[0]), .done(done_v[0])
    );
    param_pattern_seq #(.INV_MASK(4'b1111)) u1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .o(o1), .busy(busy_v[1]), .done(done_v[1])
    );
    param_pattern_seq #(
        .INIT_VAL(4'b0101), .STEPS(3), .HOLD(1), .MODE(1)
    ) u2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .o(o2), .busy(busy_v[2]), .done(done_v[2])
    );
    param_pattern_seq #(
        .WIDTH(5), .INIT_VAL(5'b10010), .INV_MASK(5'b00110),
        .STEPS(2), .HOLD(3), .MODE(2)
    ) u3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .o(o3), .busy(busy_v[3]), .done(done_v[3])
    );
    param_pattern_seq #(
        .WIDTH(1), .INIT_VAL(1'b1), .INV_MASK(1'b0),
        .STEPS(3), .HOLD(1), .MODE(0)
    ) u4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .o(o4), .busy(busy_v[4]), .done(done_v[4])
    );

    // Model: a run is just a cycle index k into STEPS*HOLD cycles.
    bit m_act [NI];
    int m_k [NI];
    bit m_done [NI];

    function automatic int exp_pat(input int i, input int n);
        int w, msk, init, r;
        w = CW[i];
        msk = (1 << w) - 1;
        init = CI[i];
        case (CMD[i])
            0: begin
                r = n % w;
                return ((init << r) | (init >> (w - r))) & msk;
            end
            1: return (n % 2 == 1) ? (~init & msk) : init;
            default: return init;
        endcase
    endfunction

    function automatic int exp_o(input int i);
        int p;
        p = m_act[i] ? exp_pat(i, m_k[i] / CH[i]) : CI[i];
        return (p ^ CM[i]) & ((1 << CW[i]) - 1);
    endfunction

    function automatic logic [31:0] get_o(input int i);
        case (i)
            0: return 32'(o0);
            1: return 32'(o1);
            2: return 32'(o2);
            3: return 32'(o3);
            default: return 32'(o4);
        endcase
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_act[i] = 1'b0;
                m_k[i] = 0;
                m_done[i] = 1'b0;
            end else if (m_act[i]) begin
                if (stop) begin
                    m_act[i] = 1'b0;
                    m_k[i] = 0;
                    m_done[i] = 1'b0;
                end else if (m_k[i] == CS[i] * CH[i] - 1) begin
                    m_done[i] = 1'b1;
                    m_k[i] = 0;
                    m_act[i] = LOOP;
                end else begin
                    m_k[i] = m_k[i] + 1;
                    m_done[i] = 1'b0;
                end
            end else begin
                // A pending done cycle (non-loop) ignores start.
                if (!m_done[i] && start && !stop) begin
                    m_act[i] = 1'b1;
                    m_k[i] = 0;
                end
                m_done[i] = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("model_o%0d", i), get_o(i), 32'(exp_o(i)));
                chk($sformatf("model_busy%0d", i), 32'(busy_v[i]), 32'(m_act[i]));
                chk($sformatf("model_done%0d", i), 32'(done_v[i]), 32'(m_done[i]));
            end
        end
    end

    task automatic step(input bit s, input bit p, input bit r);
        start = s;
        stop = p;
        rst = r;
        @(negedge clk);
    endtask

    logic [3:0] seq0 [8];
    logic [3:0] seq2 [3];
    int nbusy;
    bit saw_done;

    initial begin
        seq0 = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8};
        seq2 = '{4'h5, 4'hA, 4'h5};
        @(negedge clk);
        step(0, 0, 1);
        chk_en = 1'b1;

        chk("rst_o0", 32'(o0), 32'h1);
        chk("rst_o1", 32'(o1), 32'hE);
        chk("rst_busy0", 32'(busy_v[0]), 32'h0);
        chk("rst_done0", 32'(done_v[0]), 32'h0);

        step(1, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("t1_o0_k%0d", k), 32'(o0), 32'((k <= 8) ? seq0[k-1] : 4'h1));
            chk($sformatf("t1_busy0_k%0d", k), 32'(busy_v[0]), 32'(LOOP || k <= 8));
            chk($sformatf("t1_done0_k%0d", k), 32'(done_v[0]), 32'(k == 9));
            if (k <= 3) begin
                chk($sformatf("t3_o2_k%0d", k), 32'(o2), 32'(seq2[k-1]));
            end
            if (k == 4) begin
                chk("t3_done2", 32'(done_v[2]), 32'h1);
            end
            if (k == 3) begin
                chk("t2_o1", 32'(o1), 32'hD);
            end
            step(0, 0, 0);
        end
`ifdef PATTERN_SEQ_LOOP_EN
        for (int k = 11; k <= 21; k++) begin
            chk($sformatf("t6_busy0_k%0d", k), 32'(busy_v[0]), 32'(k <= 20));
            chk($sformatf("t6_done0_k%0d", k), 32'(done_v[0]), 32'(k == 17));
            step(0, k == 20, 0);
        end
`endif
        repeat (3) step(0, 0, 0);

        step(1, 0, 0);
        repeat (3) step(0, 0, 0);
        step(0, 1, 0);
        chk("t4_stop_o0", 32'(o0), 32'h1);
        chk("t4_stop_busy0", 32'(busy_v[0]), 32'h0);
        chk("t4_stop_done0", 32'(done_v[0]), 32'h0);
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            saw_done |= done_v[0];
            step(0, 0, 0);
        end
        chk("t4_no_done0", 32'(saw_done), 32'h0);
        step(1, 1, 0);
        chk("t4_both_busy0", 32'(busy_v[0]), 32'h0);
        step(0, 0, 0);
        chk("t4_both_busy0_b", 32'(busy_v[0]), 32'h0);

        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        chk("t5_rst_o0", 32'(o0), 32'h1);
        chk("t5_rst_busy0", 32'(busy_v[0]), 32'h0);
        chk("t5_rst_done0", 32'(done_v[0]), 32'h0);
        step(1, 0, 0);
        nbusy = 0;
        for (int k = 1; k <= 8; k++) begin
            nbusy += int'(busy_v[0]);
            step(0, 0, 0);
        end
        chk("t5_busy_len0", 32'(nbusy), 32'd8);
        chk("t5_done0", 32'(done_v[0]), 32'h1);
        step(0, 1, 0);
        repeat (6) step(0, 0, 0);

        for (int c = 0; c < 4000; c++) begin
            step($urandom_range(0, 3) == 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 99) == 0);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
